// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Direct-mapped BTB with 2-bit saturating counters, looked up at IF to predict
//   the next fetch PC. Conditional branches are resolved in ID against the
//   prediction carried down the pipe. A mispredict raises a redirect, which also
//   flushes IF/ID. An EX-stage jump redirect overrides any ID resolution.
//   A saturating mispredict counter is kept for performance monitoring.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_if_pc               fetch PC for lookup
//   o_pred_taken/pc       BTB prediction for the fetch PC
//   i_id_*                ID branch: valid, stall, pc, imm, opcode, operands,
//                         and the prediction carried from IF
//   i_es_change_pc/pc     EX-stage jump redirect
//   o_redirect/pc         fetch redirect (IF/ID flush) and corrected PC
//   o_mispredict_cnt      saturating mispredict count
module branch_predict_unit #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned IMM_WIDTH    = 16,
    parameter int unsigned OPCODE_WIDTH = 6,
    parameter int unsigned ENTRIES      = 16,
    parameter int unsigned STAT_WIDTH   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [PC_WIDTH-1:0]     i_if_pc,
    output logic                    o_pred_taken,
    output logic [PC_WIDTH-1:0]     o_pred_pc,
    input  logic                    i_id_branch,
    input  logic                    i_id_stall,
    input  logic [PC_WIDTH-1:0]     i_id_pc,
    input  logic [IMM_WIDTH-1:0]    i_id_imm,
    input  logic [OPCODE_WIDTH-1:0] i_id_opcode,
    input  logic [DWIDTH-1:0]       i_id_data_r1,
    input  logic [DWIDTH-1:0]       i_id_data_r2,
    input  logic                    i_id_pred_taken,
    input  logic [PC_WIDTH-1:0]     i_id_pred_pc,
    input  logic                    i_es_change_pc,
    input  logic [PC_WIDTH-1:0]     i_es_pc,
    output logic                    o_redirect,
    output logic [PC_WIDTH-1:0]     o_redirect_pc,
    output logic [STAT_WIDTH-1:0]   o_mispredict_cnt
);

    localparam int unsigned IDX       = $clog2(ENTRIES);
    localparam int unsigned TAG_WIDTH = PC_WIDTH - IDX - 2;

    localparam logic [OPCODE_WIDTH-1:0] OpBeq  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OpBne  = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OpBlez = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OpBgtz = OPCODE_WIDTH'(7);

    logic                 valid_q  [ENTRIES];
    logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0]  target_q [ENTRIES];
    logic [1:0]           cnt_q    [ENTRIES];

    logic [STAT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

    // PC byte-offset bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_if_pc[1:0], i_id_pc[1:0]};

    // ---------------- IF lookup ----------------
    logic [IDX-1:0]       if_idx;
    logic [TAG_WIDTH-1:0] if_tag;
    logic                 if_hit;

    assign if_idx       = i_if_pc[IDX+1:2];
    assign if_tag       = i_if_pc[PC_WIDTH-1:IDX+2];
    assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign o_pred_taken = if_hit && cnt_q[if_idx][1];
    assign o_pred_pc    = o_pred_taken ? target_q[if_idx] : i_if_pc + PC_WIDTH'(4);

    // ---------------- ID resolution ----------------
    logic [PC_WIDTH-1:0]  imm_ext;
    logic [PC_WIDTH-1:0]  br_target;
    logic [PC_WIDTH-1:0]  id_seq_pc;
    logic                 taken;
    logic                 r1_neg, r1_zero;
    logic                 resolve, mispredict;
    logic [IDX-1:0]       id_idx;
    logic [TAG_WIDTH-1:0] id_tag;
    logic                 id_hit;

    // Size cast of a signed operand sign-extends.
    assign imm_ext   = PC_WIDTH'($signed(i_id_imm));
    assign id_seq_pc = i_id_pc + PC_WIDTH'(4);
    assign br_target = id_seq_pc + (imm_ext << 2);
    assign r1_neg    = i_id_data_r1[DWIDTH-1];
    assign r1_zero   = (i_id_data_r1 == '0);

    always_comb begin
        taken = 1'b0;
        case (i_id_opcode)
            OpBeq:   taken = (i_id_data_r1 == i_id_data_r2);
            OpBne:   taken = (i_id_data_r1 != i_id_data_r2);
            OpBlez:  taken = r1_neg || r1_zero;
            OpBgtz:  taken = !r1_neg && !r1_zero;
            default: taken = 1'b0;
        endcase
    end

    assign resolve    = i_id_branch && !i_id_stall && !i_es_change_pc;
    assign mispredict = resolve && ((taken != i_id_pred_taken) ||
                                    (taken && (i_id_pred_pc != br_target)));

    assign id_idx = i_id_pc[IDX+1:2];
    assign id_tag = i_id_pc[PC_WIDTH-1:IDX+2];
    assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

    // EX redirect outranks any ID mispredict.
    always_comb begin
        o_redirect    = 1'b0;
        o_redirect_pc = '0;
        if (i_es_change_pc) begin
            o_redirect    = 1'b1;
            o_redirect_pc = i_es_pc;
        end else if (mispredict) begin
            o_redirect    = 1'b1;
            o_redirect_pc = taken ? br_target : id_seq_pc;
        end
    end

    always_comb begin
        mis_cnt_d = mis_cnt_q;
        if (mispredict && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + STAT_WIDTH'(1);
        end
    end

    assign o_mispredict_cnt = mis_cnt_q;

    // ---------------- BTB / stats state ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
            mis_cnt_q <= '0;
        end else begin
            mis_cnt_q <= mis_cnt_d;
            if (resolve) begin
                if (id_hit) begin
                    if (taken) begin
                        if (cnt_q[id_idx] != 2'b11) begin
                            cnt_q[id_idx] <= cnt_q[id_idx] + 2'd1;
                        end
                        target_q[id_idx] <= br_target;
                    end else if (cnt_q[id_idx] != 2'b00) begin
                        cnt_q[id_idx] <= cnt_q[id_idx] - 2'd1;
                    end
                end else if (taken) begin
                    // Allocation evicts whatever aliased into this index.
                    valid_q[id_idx]  <= 1'b1;
                    tag_q[id_idx]    <= id_tag;
                    target_q[id_idx] <= br_target;
                    cnt_q[id_idx]    <= 2'b10;
                end
            end
        end
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the decode-stage branch resolver. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, looked up at IF to predict the next PC. Branches are resolved in ID against the prediction carried down the pipe, and the block issues a redirect and flush on a mispredict. An EX-stage jump redirect takes priority over any ID resolution. A saturating mispredict counter is kept for performance monitoring.

## Interface
- PC_WIDTH, 32, PC width
- DWIDTH, 32, register data width
- IMM_WIDTH, 16, branch immediate width
- OPCODE_WIDTH, 6, opcode width
- ENTRIES, 16, BTB entries; power of two, ≥2
- STAT_WIDTH, 16, mispredict counter width

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_if_pc  in  PC_WIDTH  fetch PC for lookup
- o_pred_taken  out  1  BTB predicts taken
- o_pred_pc  out  PC_WIDTH  predicted next fetch PC
- i_id_branch  in  1  ID instruction is a conditional branch
- i_id_stall  in  1  ID is stalled (operands not ready)
- i_id_pc  in  PC_WIDTH  address of the ID branch
- i_id_imm  in  IMM_WIDTH  branch immediate
- i_id_opcode  in  OPCODE_WIDTH  branch opcode
- i_id_data_r1, i_id_data_r2  in  DWIDTH  forwarded operands
- i_id_pred_taken  in  1  prediction carried from IF
- i_id_pred_pc  in  PC_WIDTH  predicted PC carried from IF
- i_es_change_pc  in  1  EX-stage jump redirect
- i_es_pc  in  PC_WIDTH  EX redirect target
- o_redirect  out  1  fetch must load o_redirect_pc; IF/ID flush
- o_redirect_pc  out  PC_WIDTH  corrected PC
- o_mispredict_cnt  out  STAT_WIDTH  saturating mispredict count

## Operation
- IDX = log2(ENTRIES). index = pc[IDX+1:2]; tag = pc[PC_WIDTH-1:IDX+2].
- Each entry holds valid, tag, target (PC_WIDTH) and cnt (2 bits).
- Lookup (combinational):
  - hit = valid[index] && tag match.
  - o_pred_taken = hit && cnt[1].
  - o_pred_pc = target if o_pred_taken, else i_if_pc+4.
- Branch target: sext(i_id_imm) to PC_WIDTH, shift left 2, add i_id_pc+4. Arithmetic is modulo 2^PC_WIDTH.
- Taken by opcode:
  - `BEQ: r1==r2.
  - `BNE: r1!=r2.
  - BLEZ (6'b000110): signed r1≤0.
  - BGTZ (6'b000111): signed r1>0.
  - Any other opcode with i_id_branch=1: not taken.
- resolve = i_id_branch && !i_id_stall && !i_es_change_pc.
- mispredict = resolve && (taken != i_id_pred_taken || (taken && i_id_pred_pc != target)).
- Redirect priority:
  1. i_es_change_pc: o_redirect=1, o_redirect_pc=i_es_pc.
  2. mispredict: o_redirect=1, o_redirect_pc = taken ? target : i_id_pc+4.
  3. Otherwise o_redirect=0 and o_redirect_pc=0.
- BTB update on a resolve edge, at the ID PC's index:
  - Hit and taken: cnt increments, saturating at 3; target is rewritten.
  - Hit and not taken: cnt decrements, saturating at 0.
  - Miss and taken: allocate (valid=1, new tag, target, cnt=2'b10), overwriting the entry at that index.
  - Miss and not taken: no change.
- o_mispredict_cnt increments on every mispredict edge and holds at all-ones. EX redirects are not counted.

## Timing
- Lookup, resolution and redirect are combinational, same cycle.
- A BTB update becomes visible to lookup on the cycle after the resolve edge. A same-cycle lookup of the index being written sees the old contents; there is no bypass.
- While i_id_stall is high there is no redirect, update or count. Resolution happens on the first unstalled cycle.
- While i_es_change_pc is high the ID branch is flushed: no update and no count.
- Reset (asynchronous, mid-operation included):
  - All valid=0 and all cnt=2'b01.
  - o_mispredict_cnt=0.
  - Outputs reflect the cleared table immediately: o_pred_taken=0, o_pred_pc=i_if_pc+4, o_redirect follows its inputs.

## Test plan
- After reset, i_if_pc=0x100 → o_pred_taken=0 and o_pred_pc=0x104.
- BEQ at 0x100, imm=4, r1=r2=5, pred_taken=0 → o_redirect=1, o_redirect_pc=0x114 and count=1. Next cycle a lookup of 0x100 → taken, 0x114.
- Taken BEQ at 0x100 four times, then one not-taken → cnt goes 2,3,3,3 then 2; the prediction stays taken. Two more not-taken (cnt 1, then 0) → prediction not taken. A mispredict with STAT_WIDTH=2 at count 3 → count stays 3.
- Same cycle: i_es_change_pc=1 with i_es_pc=0x200 and a mispredicting BNE → redirect to 0x200, no BTB update, count unchanged.
- i_id_stall=1 for 3 cycles on a mispredicting branch → o_redirect=0 throughout. On the stall release cycle → redirect and update.
- Aliasing (ENTRIES=16): allocate 0x100, then a taken branch at 0x140 → the 0x100 lookup now misses. Assert i_rst_n mid-run → all lookups not taken and the count is 0 immediately.
